sub_packetreq: RTL and testbench
================================

// Module: sub_packetreq
// PURPOSE
//  Receive-side IPbus frame parser, in the mac_clk domain between the MAC RX byte stream and the request buffer.
//  - Validates Ethernet/IPv4/UDP headers addressed to this board.
//  - Packs the UDP payload big-endian into 32-bit words and writes them to the request buffer.
//  - Holds the frame for the IPbus transactor until it is acknowledged.
//  - Captures the source MAC/IP/port so the response path can address its reply.
// PARAMETERS
//  MY_MAC     48'h000A3501F610  unicast destination MAC accepted
//  MY_IP      32'hC0A80073      destination IP accepted (192.168.0.115)
//  MY_PORT    16'd50001         UDP destination port accepted
//  MAX_WORDS  9'd368            max payload length in 32-bit words (must be <=511)
// PORTS
//  mac_clk    in   1   sole clock
//  reset_n    in   1   synchronous, active-low reset
//  rx_data    in   8   frame byte (byte 0 = first dest-MAC byte; FCS already stripped)
//  rx_valid   in   1   rx_data valid this cycle; gaps allowed mid-frame
//  rx_last    in   1   last byte of frame; qualified by rx_valid
//  rx_error   in   1   FCS/PHY error; sampled with rx_last
//  buf_we     out  1   request-buffer write strobe
//  buf_addr   out  9   word address, 0-based
//  buf_data   out  32  payload word; first payload byte in [31:24]
//  pkt_avail  out  1   level: valid request held in buffer
//  pkt_ack    in   1   consumer has finished with the buffer
//  pkt_len    out  9   payload length in words; valid while pkt_avail
//  src_mac    out  48  / src_ip out 32 / src_port out 16: sender fields; valid while pkt_avail
//  good_cnt   out  16  accepted frames, wrapping
//  drop_cnt   out  16  rejected frames, wrapping
// BEHAVIOUR
//  - Reset: all outputs 0; state SYNC.
//  - States: SYNC -> IDLE -> HDR -> PAYLOAD -> TAIL. DROP is entered from any parse state.
//  - SYNC: discard bytes until rx_valid&rx_last, then go to IDLE. This prevents reset mid-frame from parsing a tail as a header.
//  - IDLE: first valid byte is byte 0. Go to HDR, or to DROP if pkt_avail=1 (buffer owned by consumer).
//  - HDR: 11-bit byte counter bc advances only on rx_valid. Checks are made at their byte offsets; any failure -> DROP:
//     - bc 0-5 = MY_MAC.
//     - bc 12-13 = 16'h0800.
//     - bc 14 = 8'h45.
//     - bc 23 = 8'd17.
//     - bc 30-33 = MY_IP.
//     - bc 36-37 = MY_PORT.
//  - HDR captures:
//     - src_mac from bc 6-11, src_ip from bc 26-29, src_port from bc 34-35.
//     - UDP length ulen from bc 38-39.
//  - HDR exit at bc 41 (UDP checksum, ignored):
//     - Required: (ulen-8) nonzero, a multiple of 4, and <= 4*MAX_WORDS; otherwise DROP.
//     - Also DROP if the IP header checksum fails.
//     - Otherwise set wlen=(ulen-8)>>2 and go to PAYLOAD.
//  - IP checksum: 16-bit one's-complement sum of bc 14-33, with end-around carry on every add. Pass iff the final sum == 16'hFFFF.
//  - PAYLOAD: bytes shift into a 32-bit register. On each 4th byte:
//     - buf_we=1 for exactly one cycle, on the cycle after that byte, with the word index in buf_addr.
//     - Go to TAIL after word wlen-1.
//  - TAIL: discard Ethernet padding until rx_last.
//  - Frame end:
//     - rx_last with rx_error=1 in any state -> drop.
//     - rx_last in HDR or PAYLOAD (short frame) -> drop.
//     - rx_last in TAIL with no error -> accept.
//  - Accept: on the cycle after the rx_last byte:
//     - pkt_avail=1, pkt_len=wlen, good_cnt+1.
//     - Then return to IDLE.
//  - Drop: drop_cnt+1 exactly once per frame, counted when rx_last is seen; pkt_avail unchanged; return to IDLE.
//     - Buffer contents after a drop are undefined.
//     - rx_last in IDLE on the frame's first byte (1-byte frame) = drop.
//  - Handshake:
//     - pkt_ack while pkt_avail=1 clears pkt_avail on the next cycle.
//     - pkt_ack while pkt_avail=0 is ignored.
//     - src_* and pkt_len remain stable while pkt_avail=1.
//  - Simultaneous events: pkt_ack in the same cycle as a frame's byte 0 is too late; that frame drops (ownership decided at byte 0).
//  - bc saturates at 2047. Frames longer than this stay in TAIL/DROP until rx_last.
//  - Counters wrap FFFF->0000.
// STRUCTURE
//  - Package ipbus_rx_pkg:
//     - ETHERTYPE_IPV4, IP_VER_IHL, IP_PROTO_UDP.
//     - Header byte offsets (0,6,12,14,23,26,30,34,36,38,42).
//     - State encoding.
//  - One sub-module, rx_csum_acc: 16-bit one's-complement byte-pair accumulator.
//     - Inputs: clk, clear, dv_even, dv_odd, data[7:0].
//     - Output: sum[15:0].
//     - Cleared in IDLE.
// TESTING
//  - Good frame: 4 payload words, payload 01..10, ulen=24, no padding.
//     - Required: buf_we at addr 0..3 with data 32'h01020304..32'h0D0E0F10.
//     - Required: pkt_avail=1 one cycle after rx_last, pkt_len=4, src_* match the sender, good_cnt=1.
//  - Header rejects: each of wrong MAC byte 5, EtherType 0x0806, IP checksum off by 1, port 50002, ulen=13.
//     - Required: pkt_avail stays 0, drop_cnt increments 1 per frame, counts back-to-back correctly.
//  - Busy buffer: second good frame while pkt_avail=1 -> dropped, no buf_we, drop_cnt+1.
//     - Then pkt_ack -> pkt_avail=0 next cycle; a third frame is accepted.
//  - Short/err frames:
//     - rx_last at payload byte 7 of an 8-byte payload -> drop.
//     - rx_error=1 on a good frame's last byte -> drop.
//     - 18 pad bytes after payload -> accepted, pkt_len unchanged.
//  - Reset mid-frame: reset_n low for 1 cycle at byte 20 of a good frame.
//     - Required: its remaining bytes are ignored, counters stay 0.
//     - Required: the next frame is accepted.
//  - rx_valid gaps: random 0-3 idle cycles between bytes of the good frame -> identical writes and result.

Source files
------------

// File: rtl/ipbus_rx_pkg.sv
// Shared constants, header byte offsets and parser state encoding for the IPbus receive path.
package ipbus_rx_pkg;

    localparam int unsigned BC_W    = 11;
    localparam int unsigned WADDR_W = 9;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;

    localparam logic [BC_W-1:0] OFF_DST_MAC  = 11'd0;
    localparam logic [BC_W-1:0] OFF_SRC_MAC  = 11'd6;
    localparam logic [BC_W-1:0] OFF_ETYPE    = 11'd12;
    localparam logic [BC_W-1:0] OFF_IP_HDR   = 11'd14;
    localparam logic [BC_W-1:0] OFF_PROTO    = 11'd23;
    localparam logic [BC_W-1:0] OFF_SRC_IP   = 11'd26;
    localparam logic [BC_W-1:0] OFF_DST_IP   = 11'd30;
    localparam logic [BC_W-1:0] OFF_SRC_PORT = 11'd34;
    localparam logic [BC_W-1:0] OFF_DST_PORT = 11'd36;
    localparam logic [BC_W-1:0] OFF_ULEN     = 11'd38;
    localparam logic [BC_W-1:0] OFF_PAYLOAD  = 11'd42;
    localparam logic [BC_W-1:0] BC_MAX       = 11'd2047;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_TAIL,
        ST_DROP
    } state_t;

    // Byte n (0 = least significant) of a field up to 48 bits wide.
    function automatic logic [7:0] byte_of(input logic [47:0] v, input logic [2:0] n);
        return v[{n, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/rx_csum_acc.sv
// 16-bit one's-complement accumulator fed one byte at a time, high byte on even offsets.
module rx_csum_acc (
    input  logic        clk,
    input  logic        clear,
    input  logic        dv_even,
    input  logic        dv_odd,
    input  logic [7:0]  data,
    output logic [15:0] sum
);

    logic [7:0]  hi;
    logic [16:0] raw;

    assign raw = {1'b0, sum} + {1'b0, hi, data};

    // End-around carry folded in on every add; cannot overflow a second time.
    always_ff @(posedge clk) begin
        if (clear) begin
            hi  <= 8'h00;
            sum <= 16'h0000;
        end else begin
            if (dv_even) hi <= data;
            if (dv_odd)  sum <= raw[15:0] + {15'd0, raw[16]};
        end
    end

endmodule

// File: rtl/sub_packetreq.sv
// IPbus UDP frame parser: validates headers, packs payload into 32-bit buffer words
// and holds the accepted request until the transactor acknowledges it.
module sub_packetreq
    import ipbus_rx_pkg::*;
#(
    parameter logic [47:0] MY_MAC    = 48'h000A3501F610,
    parameter logic [31:0] MY_IP     = 32'hC0A80073,
    parameter logic [15:0] MY_PORT   = 16'd50001,
    parameter logic [8:0]  MAX_WORDS = 9'd368
) (
    input  logic        mac_clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    input  logic        rx_error,
    output logic        buf_we,
    output logic [8:0]  buf_addr,
    output logic [31:0] buf_data,
    output logic        pkt_avail,
    input  logic        pkt_ack,
    output logic [8:0]  pkt_len,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt
);

    state_t state, state_n;

    logic [BC_W-1:0]    bc;
    logic [BC_W-1:0]    idx;
    logic [15:0]        ulen;
    logic [15:0]        plen;
    logic [WADDR_W-1:0] wlen;
    logic [WADDR_W-1:0] wc;
    logic [1:0]         pb;
    logic [23:0]        shreg;
    logic [15:0]        csum;

    logic byte_ok;
    logic len_ok;
    logic csum_ok;
    logic hdr_byte;
    logic pay_byte;
    logic word_end;
    logic last_word;
    logic inc_good;
    logic inc_drop;
    logic to_payload;

    assign idx       = (state == ST_IDLE) ? OFF_DST_MAC : bc;
    assign hdr_byte  = (state == ST_HDR) && rx_valid;
    assign pay_byte  = (state == ST_PAYLOAD) && rx_valid;
    assign plen      = ulen - 16'd8;
    assign len_ok    = (plen != 16'd0) && (plen[1:0] == 2'b00) &&
                       (plen <= {5'd0, MAX_WORDS, 2'b00});
    assign csum_ok   = (csum == 16'hFFFF);
    assign word_end  = (pb == 2'd3);
    assign last_word = (wc == wlen - 9'd1);

    rx_csum_acc u_csum (
        .clk     (mac_clk),
        .clear   ((state == ST_IDLE) || (state == ST_SYNC)),
        .dv_even (hdr_byte && (bc >= OFF_IP_HDR) && (bc < OFF_SRC_PORT) && !bc[0]),
        .dv_odd  (hdr_byte && (bc >= OFF_IP_HDR) && (bc < OFF_SRC_PORT) &&  bc[0]),
        .data    (rx_data),
        .sum     (csum)
    );

    // Compare the current header byte against the field expected at its offset.
    always_comb begin
        byte_ok = 1'b1;
        if (idx < OFF_SRC_MAC)
            byte_ok = (rx_data == byte_of(MY_MAC, 3'(OFF_SRC_MAC - 11'd1 - idx)));
        else if (idx == OFF_ETYPE)
            byte_ok = (rx_data == ETHERTYPE_IPV4[15:8]);
        else if (idx == OFF_ETYPE + 11'd1)
            byte_ok = (rx_data == ETHERTYPE_IPV4[7:0]);
        else if (idx == OFF_IP_HDR)
            byte_ok = (rx_data == IP_VER_IHL);
        else if (idx == OFF_PROTO)
            byte_ok = (rx_data == IP_PROTO_UDP);
        else if ((idx >= OFF_DST_IP) && (idx < OFF_SRC_PORT))
            byte_ok = (rx_data == byte_of({16'h0000, MY_IP}, 3'(OFF_SRC_PORT - 11'd1 - idx)));
        else if (idx == OFF_DST_PORT)
            byte_ok = (rx_data == MY_PORT[15:8]);
        else if (idx == OFF_DST_PORT + 11'd1)
            byte_ok = (rx_data == MY_PORT[7:0]);
    end

    always_ff @(posedge mac_clk) begin
        if (!reset_n) state <= ST_SYNC;
        else          state <= state_n;
    end

    // rx_last always wins: a frame is counted exactly once, on its last byte.
    always_comb begin
        state_n    = state;
        inc_good   = 1'b0;
        inc_drop   = 1'b0;
        to_payload = 1'b0;
        case (state)
            ST_SYNC: begin
                if (rx_valid && rx_last) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_last)                   inc_drop = 1'b1;
                    else if (pkt_avail || !byte_ok) state_n = ST_DROP;
                    else                           state_n = ST_HDR;
                end
            end
            ST_HDR: begin
                if (rx_valid) begin
                    if (rx_last) begin
                        inc_drop = 1'b1;
                        state_n  = ST_IDLE;
                    end else if (!byte_ok) begin
                        state_n = ST_DROP;
                    end else if (bc == OFF_PAYLOAD - 11'd1) begin
                        if (len_ok && csum_ok) begin
                            to_payload = 1'b1;
                            state_n    = ST_PAYLOAD;
                        end else begin
                            state_n = ST_DROP;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    if (rx_last) begin
                        if (word_end && last_word && !rx_error) inc_good = 1'b1;
                        else                                   inc_drop = 1'b1;
                        state_n = ST_IDLE;
                    end else if (word_end && last_word) begin
                        state_n = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (rx_valid && rx_last) begin
                    if (rx_error) inc_drop = 1'b1;
                    else          inc_good = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (rx_valid && rx_last) begin
                    inc_drop = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            default: state_n = ST_SYNC;
        endcase
    end

    // Datapath: byte counter, header captures, payload packing, handshake and counters.
    always_ff @(posedge mac_clk) begin
        if (!reset_n) begin
            bc        <= '0;
            ulen      <= 16'd0;
            wlen      <= '0;
            wc        <= '0;
            pb        <= 2'd0;
            shreg     <= 24'd0;
            buf_we    <= 1'b0;
            buf_addr  <= 9'd0;
            buf_data  <= 32'd0;
            pkt_avail <= 1'b0;
            pkt_len   <= 9'd0;
            src_mac   <= 48'd0;
            src_ip    <= 32'd0;
            src_port  <= 16'd0;
            good_cnt  <= 16'd0;
            drop_cnt  <= 16'd0;
        end else begin
            buf_we <= 1'b0;

            if (rx_valid) begin
                if (state == ST_IDLE) begin
                    bc <= 11'd1;
                    wc <= '0;
                    pb <= 2'd0;
                end else if (bc != BC_MAX) begin
                    bc <= bc + 11'd1;
                end
            end

            if (hdr_byte && (bc >= OFF_SRC_MAC) && (bc < OFF_ETYPE))
                src_mac <= {src_mac[39:0], rx_data};
            if (hdr_byte && (bc >= OFF_SRC_IP) && (bc < OFF_DST_IP))
                src_ip <= {src_ip[23:0], rx_data};
            if (hdr_byte && (bc >= OFF_SRC_PORT) && (bc < OFF_DST_PORT))
                src_port <= {src_port[7:0], rx_data};
            if (hdr_byte && (bc >= OFF_ULEN) && (bc < OFF_ULEN + 11'd2))
                ulen <= {ulen[7:0], rx_data};
            if (to_payload)
                wlen <= plen[10:2];

            if (pay_byte) begin
                shreg <= {shreg[15:0], rx_data};
                pb    <= pb + 2'd1;
                if (word_end) begin
                    buf_we   <= 1'b1;
                    buf_addr <= wc;
                    buf_data <= {shreg, rx_data};
                    wc       <= wc + 9'd1;
                end
            end

            if (inc_good) begin
                pkt_avail <= 1'b1;
                pkt_len   <= wlen;
                good_cnt  <= good_cnt + 16'd1;
            end else if (pkt_ack) begin
                pkt_avail <= 1'b0;
            end

            if (inc_drop)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sub_packetreq.sv
// Directed bench for sub_packetreq: queued expected buffer writes and accepted-frame
// records are popped by monitors; frame status is checked after each frame.
module tb_sub_packetreq;

    logic        mac_clk;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_error;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic [31:0] buf_data;
    logic        pkt_avail;
    logic        pkt_ack;
    logic [8:0]  pkt_len;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] good_cnt;
    logic [15:0] drop_cnt;

    sub_packetreq dut (
        .mac_clk   (mac_clk),
        .reset_n   (reset_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_last   (rx_last),
        .rx_error  (rx_error),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .pkt_avail (pkt_avail),
        .pkt_ack   (pkt_ack),
        .pkt_len   (pkt_len),
        .src_mac   (src_mac),
        .src_ip    (src_ip),
        .src_port  (src_port),
        .good_cnt  (good_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial mac_clk = 1'b0;
    always #5 mac_clk = ~mac_clk;

    localparam logic [47:0] MY_MAC   = 48'h000A3501F610;
    localparam logic [47:0] SRC_MAC  = 48'h021122334455;
    localparam logic [31:0] SRC_IP   = 32'hC0A8000A;
    localparam logic [31:0] MY_IP    = 32'hC0A80073;

    typedef struct packed {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [8:0]  len;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] port;
    } acc_t;

    wr_t        wq[$];
    acc_t       accq[$];
    logic [7:0] fr[$];

    int total = 0;
    int bad   = 0;
    bit wr_dc = 1'b0;
    logic prev_avail = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge mac_clk) begin
        if (buf_we && !wr_dc) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 64'(buf_addr), 64'hFFFF);
            end else begin
                wr_t w;
                w = wq.pop_front();
                check("wr_addr", 64'(buf_addr), 64'(w.addr));
                check("wr_data", 64'(buf_data), 64'(w.data));
            end
        end
    end

    // Accept monitor: on each rising pkt_avail compare the held request fields.
    always @(negedge mac_clk) begin
        if (pkt_avail && !prev_avail) begin
            if (accq.size() == 0) begin
                check("unexpected_accept", 64'(pkt_len), 64'h1FF);
            end else begin
                acc_t a;
                a = accq.pop_front();
                check("pkt_len",  64'(pkt_len),  64'(a.len));
                check("src_mac",  64'(src_mac),  64'(a.mac));
                check("src_ip",   64'(src_ip),   64'(a.ip));
                check("src_port", 64'(src_port), 64'(a.port));
            end
        end
        prev_avail = pkt_avail;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                         input logic [15:0] sport, input logic [15:0] dport,
                         input logic [15:0] ulen, input int npay, input int npad,
                         input int csum_adj);
        logic [31:0] s;
        logic [15:0] tot;
        logic [15:0] cs;
        tot = ulen + 16'd20;
        fr.delete();
        for (int i = 5; i >= 0; i--) fr.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(SRC_MAC[8*i +: 8]);
        fr.push_back(etype[15:8]); fr.push_back(etype[7:0]);
        fr.push_back(8'h45); fr.push_back(8'h00);
        fr.push_back(tot[15:8]); fr.push_back(tot[7:0]);
        fr.push_back(8'h00); fr.push_back(8'h00);
        fr.push_back(8'h40); fr.push_back(8'h00);
        fr.push_back(8'h40); fr.push_back(8'h11);
        fr.push_back(8'h00); fr.push_back(8'h00);
        for (int i = 3; i >= 0; i--) fr.push_back(SRC_IP[8*i +: 8]);
        for (int i = 3; i >= 0; i--) fr.push_back(MY_IP[8*i +: 8]);
        fr.push_back(sport[15:8]); fr.push_back(sport[7:0]);
        fr.push_back(dport[15:8]); fr.push_back(dport[7:0]);
        fr.push_back(ulen[15:8]);  fr.push_back(ulen[7:0]);
        fr.push_back(8'h00); fr.push_back(8'h00);
        for (int i = 0; i < npay; i++) fr.push_back(8'(i + 1));
        for (int i = 0; i < npad; i++) fr.push_back(8'h00);
        s = 32'd0;
        for (int k = 14; k < 34; k += 2) s = s + {16'd0, fr[k], fr[k+1]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        cs = ~s[15:0] + 16'(csum_adj);
        fr[24] = cs[15:8];
        fr[25] = cs[7:0];
    endtask

    task automatic send(input int gapmax, input bit err, input int cut, input int rst_at);
        int n;
        int g;
        n = (cut > 0) ? cut : fr.size();
        for (int i = 0; i < n; i++) begin
            if (gapmax > 0) begin
                g = int'($urandom_range(gapmax, 0));
                repeat (g) begin
                    @(negedge mac_clk);
                    rx_valid = 1'b0; rx_last = 1'b0; rx_error = 1'b0; reset_n = 1'b1;
                end
            end
            @(negedge mac_clk);
            reset_n  = (i == rst_at) ? 1'b0 : 1'b1;
            rx_valid = 1'b1;
            rx_data  = fr[i];
            rx_last  = (i == n - 1);
            rx_error = err && (i == n - 1);
        end
        @(negedge mac_clk);
        rx_valid = 1'b0; rx_last = 1'b0; rx_error = 1'b0; reset_n = 1'b1;
    endtask

    task automatic push_words();
        wq.push_back('{addr: 9'd0, data: 32'h01020304});
        wq.push_back('{addr: 9'd1, data: 32'h05060708});
        wq.push_back('{addr: 9'd2, data: 32'h090A0B0C});
        wq.push_back('{addr: 9'd3, data: 32'h0D0E0F10});
    endtask

    task automatic good_frame(input logic [15:0] sport, input int npad, input int gapmax);
        build(MY_MAC, 16'h0800, sport, 16'd50001, 16'd24, 16, npad, 0);
        push_words();
        accq.push_back('{len: 9'd4, mac: SRC_MAC, ip: SRC_IP, port: sport});
        send(gapmax, 1'b0, 0, -1);
    endtask

    task automatic status(input string name, input logic avail, input int good, input int drop);
        check({name, "_avail"}, 64'(pkt_avail), 64'(avail));
        check({name, "_good"},  64'(good_cnt),  64'(good));
        check({name, "_drop"},  64'(drop_cnt),  64'(drop));
    endtask

    task automatic ack(input string name);
        @(negedge mac_clk);
        pkt_ack = 1'b1;
        @(negedge mac_clk);
        pkt_ack = 1'b0;
        check({name, "_ack_clear"}, 64'(pkt_avail), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        rx_last = 1'b0; rx_error = 1'b0; pkt_ack = 1'b0;
        repeat (3) @(negedge mac_clk);
        check("rst_avail",    64'(pkt_avail), 64'd0);
        check("rst_len",      64'(pkt_len),   64'd0);
        check("rst_good",     64'(good_cnt),  64'd0);
        check("rst_drop",     64'(drop_cnt),  64'd0);
        check("rst_we",       64'(buf_we),    64'd0);
        check("rst_addr",     64'(buf_addr),  64'd0);
        check("rst_data",     64'(buf_data),  64'd0);
        check("rst_src_mac",  64'(src_mac),   64'd0);
        check("rst_src_ip",   64'(src_ip),    64'd0);
        check("rst_src_port", 64'(src_port),  64'd0);
        reset_n = 1'b1;

        // Leave SYNC with a lone end-of-frame byte; not counted.
        fr.delete(); fr.push_back(8'h55);
        send(0, 1'b0, 0, -1);
        status("sync", 1'b0, 0, 0);

        good_frame(16'hABCD, 0, 0);
        status("good1", 1'b1, 1, 0);

        // Buffer still owned: whole frame dropped at byte 0, no writes.
        build(MY_MAC, 16'h0800, 16'hBEEF, 16'd50001, 16'd24, 16, 0, 0);
        send(0, 1'b0, 0, -1);
        status("busy", 1'b1, 1, 1);
        ack("busy");

        good_frame(16'h1111, 0, 0);
        status("good3", 1'b1, 2, 1);
        ack("good3");

        build(48'h000A3501F611, 16'h0800, 16'h1234, 16'd50001, 16'd24, 16, 0, 0);
        send(0, 1'b0, 0, -1);
        status("bad_mac", 1'b0, 2, 2);
        build(MY_MAC, 16'h0806, 16'h1234, 16'd50001, 16'd24, 16, 0, 0);
        send(0, 1'b0, 0, -1);
        status("bad_etype", 1'b0, 2, 3);
        build(MY_MAC, 16'h0800, 16'h1234, 16'd50001, 16'd24, 16, 0, 1);
        send(0, 1'b0, 0, -1);
        status("bad_csum", 1'b0, 2, 4);
        build(MY_MAC, 16'h0800, 16'h1234, 16'd50002, 16'd24, 16, 0, 0);
        send(0, 1'b0, 0, -1);
        status("bad_port", 1'b0, 2, 5);
        build(MY_MAC, 16'h0800, 16'h1234, 16'd50001, 16'd13, 5, 0, 0);
        send(0, 1'b0, 0, -1);
        status("bad_ulen", 1'b0, 2, 6);

        fr.delete(); fr.push_back(8'h00);
        send(0, 1'b0, 0, -1);
        status("one_byte", 1'b0, 2, 7);

        // Buffer contents are don't-care on dropped frames.
        wr_dc = 1'b1;
        build(MY_MAC, 16'h0800, 16'h1234, 16'd50001, 16'd16, 8, 0, 0);
        send(0, 1'b0, 49, -1);
        status("short", 1'b0, 2, 8);
        build(MY_MAC, 16'h0800, 16'h1234, 16'd50001, 16'd24, 16, 0, 0);
        send(0, 1'b1, 0, -1);
        status("rx_err", 1'b0, 2, 9);
        @(negedge mac_clk);
        wr_dc = 1'b0;

        good_frame(16'h2222, 18, 0);
        status("padded", 1'b1, 3, 9);
        ack("padded");

        // Reset at byte 20: the tail must be swallowed by SYNC.
        build(MY_MAC, 16'h0800, 16'h5555, 16'd50001, 16'd24, 16, 0, 0);
        send(0, 1'b0, 0, 20);
        status("mid_reset", 1'b0, 0, 0);

        good_frame(16'h3333, 0, 0);
        status("after_reset", 1'b1, 1, 0);
        ack("after_reset");

        good_frame(16'h4444, 0, 3);
        status("gaps", 1'b1, 2, 0);
        ack("gaps");

        repeat (4) @(negedge mac_clk);
        check("writes_left",  64'(wq.size()),   64'd0);
        check("accepts_left", 64'(accq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
